// File: rtl/mem_dump_unit.sv
// mem_dump_unit: drains an inclusive, wrap-around SRAM address range onto a valid/ready stream.
// Optional checksum beat after the data beats: define DUMP_CHECKSUM_EN to build it.
module mem_dump_unit #(
  parameter int WORD_SIZE = 8,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_SIZE-1:0] first_addr,
  input  logic [ADDR_SIZE-1:0] last_addr,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_rd,
  output logic [ADDR_SIZE-1:0] mem_addr,
  input  logic [WORD_SIZE-1:0] mem_data,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic [WORD_SIZE-1:0] dout_data,
  output logic [ADDR_SIZE-1:0] dout_addr,
  output logic                 dout_is_sum
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    WAIT = 3'd2,
    SEND = 3'd3,
    SUM  = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [ADDR_SIZE-1:0]   r_cur;
  logic [ADDR_SIZE-1:0]   r_last;
  logic [WORD_SIZE-1:0]   r_dout_data;
  logic [ADDR_SIZE-1:0]   r_dout_addr;
  logic                   w_accept;
  logic                   w_xfer;
  logic                   w_at_last;

  assign w_accept  = (r_state == IDLE) && start;
  assign w_xfer    = dout_valid && dout_ready;
  assign w_at_last = (r_cur == r_last);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: next is given a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (start) w_next = ADDR;
      ADDR: w_next = WAIT;
      WAIT: w_next = SEND;
      SEND: begin
        if (dout_ready) begin
          if (w_at_last) begin
`ifdef DUMP_CHECKSUM_EN
            w_next = SUM;
`else
            w_next = DONE;
`endif
          end else begin
            w_next = ADDR;
          end
        end
      end
`ifdef DUMP_CHECKSUM_EN
      SUM:  if (dout_ready) w_next = DONE;
`endif
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Range pointers: cur advances only on an accepted beat, so a stalled beat never skips.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cur  <= '0;
      r_last <= '0;
    end else if (w_accept) begin
      r_cur  <= first_addr;
      r_last <= last_addr;
    end else if ((r_state == SEND) && dout_ready && !w_at_last) begin
      r_cur  <= r_cur + ADDR_SIZE'(1);
    end
  end

  // SRAM data is valid during WAIT; capture it once and hold it for the whole SEND.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dout_data <= '0;
      r_dout_addr <= '0;
    end else if (r_state == WAIT) begin
      r_dout_data <= mem_data;
      r_dout_addr <= r_cur;
    end
  end

`ifdef DUMP_CHECKSUM_EN
  logic [WORD_SIZE-1:0] r_sum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sum <= '0;
    end else if (w_accept) begin
      r_sum <= '0;
    end else if (r_state == WAIT) begin
      r_sum <= r_sum + mem_data;
    end
  end
`endif

  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    mem_rd      = 1'b0;
    mem_addr    = '0;
    dout_valid  = 1'b0;
    dout_data   = r_dout_data;
    dout_addr   = r_dout_addr;
    dout_is_sum = 1'b0;
    unique case (r_state)
      ADDR: begin
        busy     = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = r_cur;
      end
      WAIT: busy = 1'b1;
      SEND: begin
        busy       = 1'b1;
        dout_valid = 1'b1;
      end
`ifdef DUMP_CHECKSUM_EN
      SUM: begin
        busy        = 1'b1;
        dout_valid  = 1'b1;
        dout_is_sum = 1'b1;
        dout_data   = r_sum;
        dout_addr   = r_last;
      end
`endif
      DONE: done = 1'b1;
      default: ;
    endcase
  end

`ifndef SYNTHESIS
  // A presented beat must stay put until the consumer takes it.
  a_hold: assert property (@(posedge clk) disable iff (!rst)
    (dout_valid && !dout_ready) |=>
      (dout_valid && $stable(dout_data) && $stable(dout_addr) && $stable(dout_is_sum)));

  a_done_pulse: assert property (@(posedge clk) disable iff (!rst) done |=> !done);

  a_xfer_unused: assert property (@(posedge clk) disable iff (!rst)
    w_xfer |-> ((r_state == SEND) || (r_state == SUM)));
`endif

endmodule

// File: tb/tb_mem_dump_unit.sv
// Scoreboard bench for mem_dump_unit: directed dumps push expected beats, a monitor pops on transfer.
// Works with and without DUMP_CHECKSUM_EN.
module tb_mem_dump_unit;

  typedef struct packed {
    logic       is_sum;
    logic [7:0] addr;
    logic [7:0] data;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] first_addr = '0;
  logic [7:0] last_addr = '0;
  logic       busy, done, mem_rd;
  logic [7:0] mem_addr;
  logic [7:0] mem_data = '0;
  logic       dout_valid;
  logic       dout_ready = 1'b1;
  logic [7:0] dout_data;
  logic [7:0] dout_addr;
  logic       dout_is_sum;

  logic [7:0] mem [256];
  beat_t      q [$];
  int         total = 0;
  int         bad = 0;
  time        t_e0 = 0;

  mem_dump_unit #(.WORD_SIZE(8), .ADDR_SIZE(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .first_addr  (first_addr),
    .last_addr   (last_addr),
    .busy        (busy),
    .done        (done),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .dout_data   (dout_data),
    .dout_addr   (dout_addr),
    .dout_is_sum (dout_is_sum)
  );

  always #5 clk = ~clk;

  // Synchronous-read SRAM: data appears one cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd) mem_data <= mem[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected beat per transfer and checks stalled beats stay unchanged.
  initial begin
    beat_t      exp_b;
    logic [17:0] held = '0;
    logic        stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled)
          check("stalled beat held", {dout_valid, dout_is_sum, dout_addr, dout_data}, {1'b1, held[16:0]});
        if (dout_valid && dout_ready) begin
          if (q.size() == 0) begin
            check("unexpected beat", {dout_is_sum, dout_addr, dout_data}, 32'hDEAD_BEEF);
          end else begin
            exp_b = q.pop_front();
            check("beat", {dout_is_sum, dout_addr, dout_data}, exp_b);
          end
          stalled = 1'b0;
        end else if (dout_valid) begin
          stalled = 1'b1;
          held    = {1'b1, dout_is_sum, dout_addr, dout_data};
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  task automatic do_start(input logic [7:0] f, input logic [7:0] l);
    @(posedge clk);
    #1;
    start      = 1'b1;
    first_addr = f;
    last_addr  = l;
    @(posedge clk);
    t_e0 = $time;
    #1;
    start = 1'b0;
  endtask

  // Pushes the beats a dump of [f..l] must produce; returns the word count.
  task automatic push_range(input logic [7:0] f, input logic [7:0] l, output int n);
    logic [7:0] a;
    logic [7:0] sum;
    a   = f;
    sum = '0;
    n   = 0;
    for (int k = 0; k < 256; k++) begin
      q.push_back({1'b0, a, mem[a]});
      sum = sum + mem[a];
      n++;
      if (a == l) break;
      a = a + 8'd1;
    end
`ifdef DUMP_CHECKSUM_EN
    q.push_back({1'b1, l, sum});
`endif
  endtask

  function automatic int dump_latency(input int n);
`ifdef DUMP_CHECKSUM_EN
    return 3 * n + 2;
`else
    return 3 * n + 1;
`endif
  endfunction

  // Waits (bounded) for done; latency counts cycles from the start edge to the end of the done pulse.
  task automatic wait_done(input string name, input int exp_lat);
    int n;
    bit found;
    n     = 0;
    found = 1'b0;
    while ((n < 3000) && !found) begin
      @(negedge clk);
      n++;
      if (done) found = 1'b1;
    end
    check({name, " done seen"}, 32'(found), 32'd1);
    if (found) begin
      check({name, " busy low at done"}, 32'(busy), 32'd0);
      if (exp_lat >= 0)
        check({name, " latency"}, 32'(int'(($time - t_e0 + 5) / 10)), 32'(exp_lat));
      @(negedge clk);
      check({name, " done one cycle, idle"}, {30'd0, done, busy}, 32'd0);
    end
    check({name, " scoreboard drained"}, 32'(q.size()), 32'd0);
  endtask

  initial begin
    int n;
    int budget;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
    mem[128] = 8'd6;
    mem[129] = 8'd1;
    mem[130] = 8'd2;
    mem[131] = 8'd0;
    mem[139] = 8'hF0;

    // Reset state
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs",
          {busy, done, mem_rd, mem_addr, dout_valid, dout_data, dout_addr, dout_is_sum}, 32'd0);
    rst = 1'b1;

    // Basic dump with hand-computed beats and first-beat timing
    q.push_back({1'b0, 8'd128, 8'd6});
    q.push_back({1'b0, 8'd129, 8'd1});
    q.push_back({1'b0, 8'd130, 8'd2});
    q.push_back({1'b0, 8'd131, 8'd0});
`ifdef DUMP_CHECKSUM_EN
    q.push_back({1'b1, 8'd131, 8'h09});
`endif
    do_start(8'd128, 8'd131);
    check("ADDR phase rd/addr/busy", {busy, mem_rd, dout_valid, mem_addr}, {1'b1, 1'b1, 1'b0, 8'd128});
    @(posedge clk); #1;
    check("WAIT phase no valid", {busy, mem_rd, dout_valid}, 3'b100);
    @(posedge clk); #1;
    check("first beat at start+2", {dout_valid, dout_addr, dout_data}, {1'b1, 8'd128, 8'd6});
    wait_done("basic", dump_latency(4));

    // Backpressure on beat (129,1) plus an ignored start while busy
    void'(q.size());
    push_range(8'd128, 8'd131, n);
    do_start(8'd128, 8'd131);
    repeat (4) @(posedge clk);
    #1 dout_ready = 1'b0;
    @(posedge clk); #1;
    check("stalled beat visible", {dout_valid, dout_addr, dout_data}, {1'b1, 8'd129, 8'd1});
    @(posedge clk); #1;
    start      = 1'b1;
    first_addr = 8'd0;
    last_addr  = 8'd0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 dout_ready = 1'b1;
    wait_done("backpressure", -1);
    repeat (4) @(negedge clk);
    check("ignored start left idle", {30'd0, busy, dout_valid}, 32'd0);

    // Wrap 254..1
    push_range(8'd254, 8'd1, n);
    check("wrap word count", 32'(n), 32'd4);
    do_start(8'd254, 8'd1);
    wait_done("wrap", dump_latency(4));

    // Single word
    q.push_back({1'b0, 8'd139, 8'hF0});
`ifdef DUMP_CHECKSUM_EN
    q.push_back({1'b1, 8'd139, 8'hF0});
`endif
    do_start(8'd139, 8'd139);
    wait_done("single", dump_latency(1));

    // Full space
    push_range(8'd0, 8'd255, n);
    check("full word count", 32'(n), 32'd256);
    do_start(8'd0, 8'd255);
    wait_done("full", dump_latency(256));

    // Reset mid-dump, then a fresh dump from a new first address
    push_range(8'd10, 8'd20, n);
    do_start(8'd10, 8'd20);
    budget = 0;
    while (!dout_valid && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    check("reached SEND before reset", 32'(dout_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async reset outputs",
          {busy, done, mem_rd, mem_addr, dout_valid, dout_data, dout_addr, dout_is_sum}, 32'd0);
    q.delete();
    @(posedge clk);
    #3 rst = 1'b1;
    push_range(8'd50, 8'd51, n);
    do_start(8'd50, 8'd51);
    wait_done("after reset", dump_latency(2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
